// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback
// sources, with one registered output stage and a drop counter for r0 writes.

module regfile_wr_lane (
  input  logic        gnt,
  input  logic [4:0]  rw,
  input  logic [31:0] data,
  output logic [4:0]  rw_g,
  output logic [31:0] data_g
);
  // Gated lane fields are OR-combined upstream, so a one-hot grant forms the mux.
  assign rw_g   = gnt ? rw   : 5'd0;
  assign data_g = gnt ? data : 32'd0;
endmodule

module regfile_wr_arbiter #(
  parameter int NREQ = 3,
  parameter int SRCW = 2,
  parameter int CNTW = 8
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 hold,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [5*NREQ-1:0]    req_rw,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 RegWr,
  output logic [4:0]           Rw,
  output logic [31:0]          busW,
  output logic [SRCW-1:0]      wr_src,
  output logic [31:0]          pending,
  output logic [CNTW-1:0]      zero_drops
);

  logic [SRCW-1:0]             ptr;
  logic [SRCW-1:0]             gnt_idx;
  logic [SRCW-1:0]             ptr_nxt;
  logic                        gnt_any;
  logic [SRCW:0]               cand;
  logic [NREQ-1:0][4:0]        lane_rw;
  logic [NREQ-1:0][31:0]       lane_data;
  logic [4:0]                  sel_rw;
  logic [31:0]                 sel_data;

  // Search from ptr upward, wrapping at NREQ; first valid requester wins.
  always_comb begin
    req_ready = '0;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (SRCW+1)'(k);
      if (cand >= (SRCW+1)'(NREQ)) cand = cand - (SRCW+1)'(NREQ);
      if (!gnt_any && req_valid[cand[SRCW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[SRCW-1:0];
      end
    end
    if (rstb || hold) gnt_any = 1'b0;
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  regfile_wr_lane u_lane [NREQ-1:0] (
    .gnt    (req_ready),
    .rw     (req_rw),
    .data   (req_data),
    .rw_g   (lane_rw),
    .data_g (lane_data)
  );

  always_comb begin
    sel_rw   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_rw   = sel_rw   | lane_rw[i];
      sel_data = sel_data | lane_data[i];
    end
  end

  assign ptr_nxt = (gnt_idx == SRCW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rstb) begin
      ptr        <= '0;
      RegWr      <= 1'b0;
      Rw         <= '0;
      busW       <= '0;
      wr_src     <= '0;
      zero_drops <= '0;
    end else if (gnt_any) begin
      ptr    <= ptr_nxt;
      Rw     <= sel_rw;
      busW   <= sel_data;
      wr_src <= gnt_idx;
      RegWr  <= (sel_rw != 5'd0);
      if (sel_rw == 5'd0 && !(&zero_drops)) zero_drops <= zero_drops + 1'b1;
    end else begin
      RegWr <= 1'b0;
    end
  end

  assign pending = RegWr ? (32'd1 << Rw) : 32'd0;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized and directed checks of regfile_wr_arbiter against a cycle-level
// behavioural model of the round-robin write-port sharing rules.

module tb_regfile_wr_arbiter;
  localparam int NREQ = 3;

  logic              clk = 1'b0;
  logic              rstb, hold;
  logic [NREQ-1:0]   req_valid;
  logic [5*NREQ-1:0] req_rw;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              RegWr;
  logic [4:0]        Rw;
  logic [31:0]       busW;
  logic [1:0]        wr_src;
  logic [31:0]       pending;
  logic [7:0]        zero_drops;

  logic [4:0]  rw_in   [NREQ];
  logic [31:0] data_in [NREQ];

  int total = 0, bad = 0;

  int          m_ptr, m_src, m_cnt;
  logic        m_regwr;
  logic [4:0]  m_rw;
  logic [31:0] m_busw;

  regfile_wr_arbiter #(.NREQ(NREQ), .SRCW(2), .CNTW(8)) dut (
    .clk(clk), .rstb(rstb), .hold(hold), .req_valid(req_valid),
    .req_rw(req_rw), .req_data(req_data), .req_ready(req_ready),
    .RegWr(RegWr), .Rw(Rw), .busW(busW), .wr_src(wr_src),
    .pending(pending), .zero_drops(zero_drops)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_rw   = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_rw[5*i +: 5]    = rw_in[i];
      req_data[32*i +: 32] = data_in[i];
    end
  end

  function automatic int model_pick();
    if (rstb || hold) return -1;
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    int g;
    g = model_pick();
    return (g >= 0) ? NREQ'(1 << g) : '0;
  endfunction

  function automatic logic [31:0] exp_pending();
    return m_regwr ? (32'd1 << m_rw) : 32'd0;
  endfunction

  // One rising edge; model advances using the inputs sampled at that edge.
  task automatic cyc(output int g);
    g = model_pick();
    @(posedge clk);
    if (rstb) begin
      m_ptr = 0; m_regwr = 0; m_rw = 0; m_busw = 0; m_src = 0; m_cnt = 0;
    end else if (g >= 0) begin
      m_rw    = rw_in[g];
      m_busw  = data_in[g];
      m_src   = g;
      m_ptr   = (g + 1) % NREQ;
      m_regwr = (rw_in[g] != 0);
      if (rw_in[g] == 0 && m_cnt < 255) m_cnt++;
    end else begin
      m_regwr = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    int g;
    rstb = 1; req_valid = '0; hold = 0;
    cyc(g);
    rstb = 0;
  endtask

  task automatic test_reset();
    int g;
    rstb = 1; hold = 0; req_valid = 3'b111;
    for (int i = 0; i < NREQ; i++) begin rw_in[i] = 5'(i + 9); data_in[i] = $urandom; end
    for (int c = 0; c < 3; c++) begin
      #1; total++;
      if (req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
      cyc(g);
    end
    rstb = 0; #1;
    total++;
    if (RegWr !== 1'b0 || Rw !== 5'd0 || busW !== 32'd0 || wr_src !== 2'd0 || zero_drops !== 8'd0) begin
      bad++; $display("FAIL reset_state got=%b/%0d/%h/%0d/%0d exp=0", RegWr, Rw, busW, wr_src, zero_drops);
    end
    total++;
    if (req_ready !== 3'b001) begin bad++; $display("FAIL reset_first_grant got=%b exp=001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_single();
    int g;
    req_valid = 3'b010; rw_in[1] = 5'd5; data_in[1] = 32'hDEADBEEF; #1;
    total++;
    if (req_ready !== 3'b010) begin bad++; $display("FAIL single_ready got=%b exp=010", req_ready); end
    cyc(g);
    req_valid = '0; #1;
    total++;
    if (RegWr !== 1'b1 || Rw !== 5'd5 || busW !== 32'hDEADBEEF || wr_src !== 2'd1) begin
      bad++; $display("FAIL single_port got=%b/%0d/%h/%0d exp=1/5/deadbeef/1", RegWr, Rw, busW, wr_src);
    end
    total++;
    if (pending !== 32'h00000020) begin bad++; $display("FAIL single_pending got=%h exp=00000020", pending); end
    cyc(g);
    total++;
    if (RegWr !== 1'b0 || pending !== 32'h0) begin
      bad++; $display("FAIL single_idle got=%b/%h exp=0/0", RegWr, pending);
    end
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin rw_in[i] = 5'(i + 1); data_in[i] = $urandom; end
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1; total++;
      if (req_ready !== NREQ'(1 << (k % 3))) begin
        bad++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, req_ready, NREQ'(1 << (k % 3)));
      end
      cyc(g);
      total++;
      if (RegWr !== 1'b1 || wr_src !== 2'(k % 3) || Rw !== 5'(k % 3 + 1) || busW !== data_in[k % 3]) begin
        bad++; $display("FAIL rr_port[%0d] got=%b/%0d/%0d exp=1/%0d/%0d", k, RegWr, wr_src, Rw, k % 3, k % 3 + 1);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_zero_drop();
    int g;
    do_reset();
    req_valid = 3'b100; rw_in[2] = 5'd0; data_in[2] = 32'h12345678; #1;
    total++;
    if (req_ready !== 3'b100) begin bad++; $display("FAIL zero_ready got=%b exp=100", req_ready); end
    cyc(g);
    total++;
    if (RegWr !== 1'b0 || pending !== 32'h0 || zero_drops !== 8'd1) begin
      bad++; $display("FAIL zero_first got=%b/%h/%0d exp=0/0/1", RegWr, pending, zero_drops);
    end
    for (int k = 1; k < 300; k++) cyc(g);
    total++;
    if (zero_drops !== 8'd255 || zero_drops !== 8'(m_cnt)) begin
      bad++; $display("FAIL zero_saturate got=%0d exp=255", zero_drops);
    end
    req_valid = '0;
  endtask

  task automatic test_hold();
    int g;
    do_reset();
    req_valid = 3'b010; rw_in[1] = 5'd4; data_in[1] = $urandom;
    cyc(g);
    req_valid = 3'b101; hold = 1;
    rw_in[0] = 5'd10; rw_in[2] = 5'd12; data_in[0] = $urandom; data_in[2] = $urandom;
    for (int c = 0; c < 4; c++) begin
      #1; total++;
      if (req_ready !== 3'b000) begin bad++; $display("FAIL hold_ready[%0d] got=%b exp=000", c, req_ready); end
      cyc(g);
      total++;
      if (RegWr !== 1'b0) begin bad++; $display("FAIL hold_regwr[%0d] got=%b exp=0", c, RegWr); end
    end
    hold = 0; #1;
    total++;
    if (req_ready !== 3'b100) begin bad++; $display("FAIL hold_first got=%b exp=100", req_ready); end
    cyc(g);
    req_valid = 3'b001; #1;
    total++;
    if (wr_src !== 2'd2 || Rw !== 5'd12 || req_ready !== 3'b001) begin
      bad++; $display("FAIL hold_second got=%0d/%0d/%b exp=2/12/001", wr_src, Rw, req_ready);
    end
    cyc(g);
    req_valid = '0;
    total++;
    if (wr_src !== 2'd0 || Rw !== 5'd10 || RegWr !== 1'b1) begin
      bad++; $display("FAIL hold_third got=%0d/%0d/%b exp=0/10/1", wr_src, Rw, RegWr);
    end
  endtask

  task automatic test_reset_mid();
    int g;
    do_reset();
    req_valid = 3'b010; rw_in[1] = 5'd0; cyc(g);
    req_valid = 3'b001; rw_in[0] = 5'd7; data_in[0] = 32'hA5A5_0007;
    cyc(g);
    req_valid = '0; rstb = 1; #1;
    total++;
    if (RegWr !== 1'b1 || Rw !== 5'd7) begin bad++; $display("FAIL mid_accept got=%b/%0d exp=1/7", RegWr, Rw); end
    cyc(g);
    rstb = 0; #1;
    total++;
    if (RegWr !== 1'b0 || Rw !== 5'd0 || busW !== 32'd0 || zero_drops !== 8'd0) begin
      bad++; $display("FAIL mid_reset got=%b/%0d/%h/%0d exp=0/0/0/0", RegWr, Rw, busW, zero_drops);
    end
    req_valid = 3'b111; #1;
    total++;
    if (req_ready !== 3'b001) begin bad++; $display("FAIL mid_ptr got=%b exp=001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_random();
    int g;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          rw_in[i]     = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
          data_in[i]   = $urandom;
        end
      hold = ($urandom_range(0, 4) == 0);
      rstb = ($urandom_range(0, 40) == 0);
      #1; total++;
      if (req_ready !== exp_ready()) begin
        bad++; $display("FAIL rand_ready[%0d] got=%b exp=%b", c, req_ready, exp_ready());
      end
      cyc(g);
      if (g >= 0) req_valid[g] = 1'b0;
      total++;
      if (RegWr !== m_regwr || Rw !== m_rw || busW !== m_busw || wr_src !== 2'(m_src) ||
          zero_drops !== 8'(m_cnt) || pending !== exp_pending()) begin
        bad++; $display("FAIL rand_port[%0d] got=%b/%0d/%h/%0d/%0d/%h exp=%b/%0d/%h/%0d/%0d/%h", c,
          RegWr, Rw, busW, wr_src, zero_drops, pending, m_regwr, m_rw, m_busw, m_src, m_cnt, exp_pending());
      end
    end
    rstb = 0; hold = 0; req_valid = '0;
  endtask

  initial begin
    rstb = 1; hold = 0; req_valid = '0;
    m_ptr = 0; m_regwr = 0; m_rw = 0; m_busw = 0; m_src = 0; m_cnt = 0;
    for (int i = 0; i < NREQ; i++) begin rw_in[i] = '0; data_in[i] = '0; end
    test_reset();
    test_single();
    test_round_robin();
    test_zero_drop();
    test_hold();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single write port of the 32x32 register file (RegWr/Rw/busW, written on the falling clock edge) between NREQ writeback requesters (default: 0 = ALU writeback, 1 = load return, 2 = multi-cycle mult/div).
- Uses round-robin arbitration with a valid/ready handshake and one registered output stage.
- Drops writes to register 0.
- Publishes a one-hot pending mask so hazard logic can see the register being written in the current cycle.

Parameters:
- NREQ, 3, number of requesters (2..4).
- SRCW, 2, width of the source-ID output; must satisfy 2^SRCW >= NREQ.
- CNTW, 8, width of the saturating zero-write drop counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rstb  in  1  synchronous, active-high reset.
- hold  in  1  when 1, no request is accepted.
- req_valid  in  NREQ  per-requester write request.
- req_rw  in  5*NREQ  destination register; requester i uses bits [5i+4:5i].
- req_data  in  32*NREQ  write data; requester i uses bits [32i+31:32i].
- req_ready  out  NREQ  one-hot grant; combinational.
- RegWr  out  1  register-file write enable; registered.
- Rw  out  5  register-file write address; registered.
- busW  out  32  register-file write data; registered.
- wr_src  out  SRCW  index of the requester whose write is on the port; registered.
- pending  out  32  one-hot mask of the register being written this cycle; combinational from registered state.
- zero_drops  out  CNTW  count of accepted writes to register 0; saturating.

Behaviour:
- Reset (rstb=1 at a rising edge):
  - RegWr=0, Rw=0, busW=0, wr_src=0, zero_drops=0, round-robin pointer ptr=0.
  - req_ready is all-zero while rstb=1, so nothing is accepted during reset, even if req_valid is high.
  - Reset asserted mid-operation discards the registered write (RegWr=0 next cycle); requesters keep their request pending.
- Handshake:
  - Requester i is accepted in a cycle when req_valid[i]=1 and req_ready[i]=1.
  - A requester must hold req_valid, req_rw and req_data stable until accepted.
  - req_ready may depend on req_valid in the same cycle.
  - At most one req_ready bit is high per cycle.
- Arbitration:
  - If hold=0 and rstb=0, grant the first valid requester found searching i = ptr, ptr+1, ..., wrapping modulo NREQ.
  - On acceptance of i: ptr <= (i+1) mod NREQ.
  - With no acceptance, ptr holds.
  - hold=1: req_ready=0 and ptr holds.
  - Fairness: a continuously valid requester is accepted within NREQ cycles in which hold=0.
- Output stage (latency 1 cycle):
  - Acceptance at rising edge t drives the port during cycle t..t+1; the register file writes at the falling edge inside that cycle.
  - On acceptance: Rw <= req_rw[i], busW <= req_data[i], wr_src <= i, RegWr <= (req_rw[i] != 0).
  - With no acceptance: RegWr <= 0; Rw, busW and wr_src hold their previous values.
  - Throughput: one write per cycle; back-to-back acceptances give RegWr high on consecutive cycles.
- Register 0:
  - An accepted request with req_rw=0 completes its handshake normally.
  - RegWr stays 0 and pending does not flag it.
  - zero_drops increments by 1 and saturates at 2^CNTW-1.
- pending = RegWr ? (1 << Rw) : 32'h0.
- Simultaneous events: two requesters targeting the same register in one cycle are serialized in round-robin order; the later one lands last.

Test Plan:
- Reset with all req_valid=1 for 3 cycles -> req_ready=000 throughout; after release, RegWr=0, ptr=0; the first cycle grants requester 0 (req_ready=001).
- Requester 1 alone, rw=5, data=32'hDEADBEEF -> req_ready=010 in the same cycle; next cycle RegWr=1, Rw=5, busW=32'hDEADBEEF, wr_src=1, pending=32'h00000020; cycle after that RegWr=0, pending=0.
- All three valid continuously, rw=1/2/3 -> acceptance order 0,1,2,0,1,2; RegWr high every cycle; wr_src sequence 0,1,2,...
- Requester 2 with rw=0, data=32'h12345678 -> accepted, RegWr stays 0, pending=0, zero_drops 0->1; after 300 such writes, zero_drops=255 (saturated).
- hold=1 for 4 cycles with req 0 and req 2 valid -> req_ready=000 and no RegWr; hold falls with ptr=2 -> requester 2 is granted first, then requester 0.
- rstb pulsed for 1 cycle immediately after acceptance of rw=7 -> RegWr=0 in the following cycle, Rw=0, busW=0, zero_drops=0, ptr=0.
